sync_ram_dp: RTL and testbench

Parametrised simple dual-port synchronous RAM. It is the next generation of the single-port 16x8 sync_ram. It adds:
- independent write and read ports usable in the same cycle
- per-byte write enables
- selectable read latency (1 or 2 cycles)
- a selectable read-during-write policy
- a hardware clear sequence after reset

It sits under datapath blocks that need scratch storage with a deterministic post-reset state.

---
 rtl/sync_ram_dp.sv | 192 +++++++++++++++++++
 tb/tb_sync_ram_dp.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_ram_dp.sv
// sync_ram_dp: simple dual-port synchronous RAM. It has one write port and one
// read port, both usable in the same cycle. The write port has per-byte
// enables. Read latency is 1 or 2 cycles. The same-address read-during-write
// policy can be selected. After reset, an optional hardware sequence clears
// every word to zero.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-high reset (synchronous release expected)
//   we         - write enable
//   waddr      - write address
//   din        - write data
//   be         - byte enables; be[i] qualifies din[8i+7:8i]
//   re         - read enable
//   raddr      - read address
//   dout       - read data; holds its last value between reads
//   dout_valid - one-cycle pulse marking dout as new data
//   busy       - clear sequence in progress; all port requests are ignored
//
// Output protocol: there is no back-pressure. Each accepted read (re=1 while
// busy=0) produces exactly one dout_valid pulse, RD_LAT edges after it was
// sampled. Results arrive in request order, one per cycle at full rate.
// dout is only meaningful in the cycle dout_valid=1, and it holds otherwise.
module sync_ram_dp #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int DEPTH          = 16,
  parameter int RD_LAT         = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     din,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  busy
);

  // Reject illegal parameter combinations at elaboration time.
  if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_chk_data_w
    $error("sync_ram_dp: DATA_W must be a positive multiple of 8");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_chk_rd_lat
    $error("sync_ram_dp: RD_LAT must be 1 or 2");
  end
  if (ADDR_W < 1 || DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_chk_depth
    $error("sync_ram_dp: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_W");
  end

  localparam int              NB       = DATA_W / 8;
  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                busy_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                waddr_ok;
  logic                raddr_ok;
  logic                wr_ok;
  logic                rd_req;
  logic                clr_we;
  logic [DATA_W-1:0]   rd_word_d;
  logic                out_req;
  logic [DATA_W-1:0]   out_word;
  logic [DATA_W-1:0]   dout_q;
  logic                dout_valid_q;

  // Words at or above DEPTH do not exist: writes there are dropped and reads
  // return zero.
  assign waddr_ok = ({1'b0, waddr} < DEPTH_L);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_L);

  assign wr_ok  = we && !busy_q && waddr_ok;
  assign rd_req = re && !busy_q;
  // Do not touch the array while reset is held. The clear sequence starts
  // on the first edge after release.
  assign clr_we = busy_q && !rst;

  // Clear/idle controller. Clearing walks word 0..DEPTH-1, one word per
  // edge. busy drops on the same edge that writes the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      clr_cnt_q <= '0;
      busy_q    <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (clr_cnt_q == CLR_LAST) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array. It has no reset, and only the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q[IDX_W-1:0]] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem_q[waddr[IDX_W-1:0]][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  // Read word as seen at this edge. The array read returns the pre-write
  // contents (old data). In write-first mode, a same-address write merges
  // its enabled lanes on top of that word.
  always_comb begin
    rd_word_d = '0;
    if (raddr_ok) begin
      rd_word_d = mem_q[raddr[IDX_W-1:0]];
      if (RDW_MODE != 0 && wr_ok && (waddr == raddr)) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) begin
            rd_word_d[8*i +: 8] = din[8*i +: 8];
          end
        end
      end
    end
  end

  // The optional extra stage delays the request and its data by one edge
  // without losing throughput.
  if (RD_LAT == 2) begin : g_lat2
    logic              pipe_valid_q;
    logic [DATA_W-1:0] pipe_data_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_valid_q <= 1'b0;
        pipe_data_q  <= '0;
      end else begin
        pipe_valid_q <= rd_req;
        if (rd_req) begin
          pipe_data_q <= rd_word_d;
        end
      end
    end

    assign out_req  = pipe_valid_q;
    assign out_word = pipe_data_q;
  end else begin : g_lat1
    assign out_req  = rd_req;
    assign out_word = rd_word_d;
  end

  // Output register: dout only changes when a result is delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= out_req;
      if (out_req) begin
        dout_q <= out_word;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sync_ram_dp.sv
// Testbench for sync_ram_dp. It drives two instances side by side.
//   u0: defaults (8-bit, 16 words, RD_LAT=1, old-data read-during-write)
//   u1: 32-bit, DEPTH=12 of 16 addresses, RD_LAT=2, write-first
// A reference memory model predicts each read result when the request is
// issued. A negedge monitor then pops and checks those results.
module tb_sync_ram_dp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  we;
  logic [1:0]  re;
  logic [3:0]  waddr [2];
  logic [3:0]  raddr [2];
  logic [31:0] din   [2];
  logic [3:0]  be    [2];
  logic [7:0]  dout0;
  logic [31:0] dout1;
  logic [1:0]  dv_v;
  logic [1:0]  busy_v;

  int          cyc = 0;
  int          compared = 0;
  int          failed = 0;

  // Reference state
  logic [31:0] mem_m  [2][16];
  int          left   [2];   // edges of clear still to come
  logic [31:0] last_d [2];   // last delivered value, which dout must hold
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int          due_q0 [$];
  int          due_q1 [$];

  // Clock and reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sync_ram_dp u0 (
    .clk        (clk),
    .rst        (rst),
    .we         (we[0]),
    .waddr      (waddr[0]),
    .din        (din[0][7:0]),
    .be         (be[0][0:0]),
    .re         (re[0]),
    .raddr      (raddr[0]),
    .dout       (dout0),
    .dout_valid (dv_v[0]),
    .busy       (busy_v[0])
  );

  sync_ram_dp #(
    .DATA_W         (32),
    .ADDR_W         (4),
    .DEPTH          (12),
    .RD_LAT         (2),
    .RDW_MODE       (1),
    .CLEAR_ON_RESET (1)
  ) u1 (
    .clk        (clk),
    .rst        (rst),
    .we         (we[1]),
    .waddr      (waddr[1]),
    .din        (din[1]),
    .be         (be[1]),
    .re         (re[1]),
    .raddr      (raddr[1]),
    .dout       (dout1),
    .dout_valid (dv_v[1]),
    .busy       (busy_v[1])
  );

  // Per-instance configuration
  function automatic int dep(int k);  return (k == 0) ? 16 : 12; endfunction
  function automatic int lat(int k);  return (k == 0) ? 1 : 2;   endfunction
  function automatic int lanes(int k); return (k == 0) ? 1 : 4;  endfunction
  function automatic bit wfirst(int k); return (k == 1);          endfunction
  function automatic logic [31:0] dmask(int k);
    return (k == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  // Reference model: apply the inputs presented for the coming edge
  function automatic void model_apply(int k);
    logic [31:0] old_w;
    logic [31:0] merged;
    logic [31:0] rd;
    bit          w_in;
    bit          r_in;
    if (rst || left[k] > 0) return;
    w_in   = (int'(waddr[k]) < dep(k));
    r_in   = (int'(raddr[k]) < dep(k));
    old_w  = w_in ? mem_m[k][waddr[k]] : 32'h0;
    merged = old_w;
    for (int i = 0; i < lanes(k); i++)
      if (be[k][i]) merged[8*i +: 8] = din[k][8*i +: 8];
    if (re[k]) begin
      if (!r_in) rd = 32'h0;
      else if (wfirst(k) && we[k] && w_in && waddr[k] == raddr[k]) rd = merged;
      else rd = mem_m[k][raddr[k]];
      if (k == 0) begin
        exp_q0.push_back(rd);
        due_q0.push_back(cyc + lat(k));
      end else begin
        exp_q1.push_back(rd);
        due_q1.push_back(cyc + lat(k));
      end
    end
    if (we[k] && w_in) mem_m[k][waddr[k]] = merged;
  endfunction

  // Driver tasks
  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      we[k] = 1'b0; re[k] = 1'b0; be[k] = 4'h0;
      din[k] = 32'h0; waddr[k] = 4'h0; raddr[k] = 4'h0;
    end
  endtask

  // One clock: the model consumes the inputs, then the edge, then idle inputs.
  task automatic step();
    for (int k = 0; k < 2; k++) model_apply(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      if (!rst && left[k] > 0) left[k] = left[k] - 1;
    #1;
    idle_inputs();
  endtask

  task automatic set_wr(int k, int a, logic [31:0] d, logic [3:0] b);
    we[k] = 1'b1; waddr[k] = 4'(a); din[k] = d & dmask(k);
    be[k] = b & 4'((1 << lanes(k)) - 1);
  endtask

  task automatic set_rd(int k, int a);
    re[k] = 1'b1; raddr[k] = 4'(a);
  endtask

  task automatic rand_inputs(int k);
    we[k]    = 1'($urandom_range(0, 1));
    waddr[k] = 4'($urandom_range(0, 15));
    din[k]   = $urandom & dmask(k);
    be[k]    = 4'($urandom_range(0, (1 << lanes(k)) - 1));
    re[k]    = 1'($urandom_range(0, 1));
    raddr[k] = ($urandom_range(0, 3) == 0) ? waddr[k] : 4'($urandom_range(0, 15));
  endtask

  task automatic do_reset(int hold);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      left[k]   = dep(k);
      last_d[k] = 32'h0;
      for (int a = 0; a < 16; a++) mem_m[k][a] = 32'h0;
    end
    exp_q0.delete(); exp_q1.delete();
    due_q0.delete(); due_q1.delete();
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Count the cycles with busy high after release. Optional junk requests
  // during that time must be ignored.
  task automatic count_busy(bit junk);
    int n [2];
    n[0] = 0; n[1] = 0;
    for (int c = 0; c < 24; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (busy_v[k] === 1'b1) n[k]++;
        if (junk) rand_inputs(k);
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (n[k] != dep(k)) begin
        failed++;
        $display("FAIL busy_len[u%0d]: got %0d cycles, want %0d", k, n[k], dep(k));
      end
    end
  endtask

  // Scoreboard monitor
  logic [31:0] mon_act;
  logic [31:0] mon_exp;
  int          mon_due;
  int          mon_n;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mon_act = (k == 0) ? {24'h0, dout0} : dout1;
      mon_n   = (k == 0) ? exp_q0.size() : exp_q1.size();
      compared++;
      if (busy_v[k] !== 1'(left[k] > 0)) begin
        failed++;
        $display("FAIL busy[u%0d] cyc %0d: got %b, want %b", k, cyc, busy_v[k], left[k] > 0);
      end
      if (dv_v[k] === 1'b1) begin
        compared++;
        if (mon_n == 0) begin
          failed++;
          $display("FAIL unexpected_valid[u%0d] cyc %0d: dout=%h with no request pending", k, cyc, mon_act);
        end else begin
          if (k == 0) begin mon_exp = exp_q0.pop_front(); mon_due = due_q0.pop_front(); end
          else        begin mon_exp = exp_q1.pop_front(); mon_due = due_q1.pop_front(); end
          if (mon_act !== mon_exp) begin
            failed++;
            $display("FAIL rd_data[u%0d] cyc %0d: got %h, want %h", k, cyc, mon_act, mon_exp);
          end
          compared++;
          if (cyc != mon_due) begin
            failed++;
            $display("FAIL rd_latency[u%0d]: result at cycle %0d, want cycle %0d", k, cyc, mon_due);
          end
          last_d[k] = mon_exp;
        end
      end else begin
        compared++;
        if (dv_v[k] !== 1'b0 || mon_act !== last_d[k]) begin
          failed++;
          $display("FAIL hold[u%0d] cyc %0d: got dout=%h valid=%b, want dout=%h valid=0",
                   k, cyc, mon_act, dv_v[k], last_d[k]);
        end
        mon_due = (k == 0) ? ((mon_n > 0) ? due_q0[0] : -1) : ((mon_n > 0) ? due_q1[0] : -1);
        if (mon_n > 0 && mon_due <= cyc) begin
          compared++;
          failed++;
          $display("FAIL missing_valid[u%0d] cyc %0d: result due at cycle %0d", k, cyc, mon_due);
          if (k == 0) begin void'(exp_q0.pop_front()); void'(due_q0.pop_front()); end
          else        begin void'(exp_q1.pop_front()); void'(due_q1.pop_front()); end
        end
      end
    end
  end

  // Stimulus
  initial begin
    idle_inputs();
    do_reset(3);

    // Clear length, with junk requests during clear that must be ignored
    count_busy(1'b1);

    // Read every address back-to-back (u1: 12..15 are out of range)
    for (int a = 0; a < 16; a++) begin
      for (int k = 0; k < 2; k++) set_rd(k, a);
      step();
    end
    repeat (3) step();

    // Simple writes, then three back-to-back reads, then idle to check hold
    for (int k = 0; k < 2; k++) set_wr(k, 1, 32'd55, 4'hF);
    step();
    for (int k = 0; k < 2; k++) set_wr(k, 2, 32'd100, 4'hF);
    step();
    for (int k = 0; k < 2; k++) set_wr(k, 3, 32'd200, 4'hF);
    step();
    for (int a = 1; a <= 3; a++) begin
      for (int k = 0; k < 2; k++) set_rd(k, a);
      step();
    end
    repeat (4) step();

    // Byte enables on u1, plus be=0 no-op writes on both instances
    set_wr(1, 5, 32'hAABB_CCDD, 4'hF); step();
    set_wr(1, 5, 32'h1122_3344, 4'h5); step();
    set_wr(0, 1, 32'hEE, 4'h0); set_wr(1, 1, 32'hEEEE_EEEE, 4'h0); step();
    set_rd(1, 5); set_rd(0, 1); step();
    set_rd(1, 1); step();
    repeat (3) step();

    // Read-during-write at the same address
    for (int k = 0; k < 2; k++) set_wr(k, 7, 32'h10, 4'hF);
    step();
    for (int k = 0; k < 2; k++) begin set_wr(k, 7, 32'h99, 4'hF); set_rd(k, 7); end
    step();
    for (int k = 0; k < 2; k++) set_rd(k, 7);
    step();
    repeat (3) step();

    // Out-of-range write on u1, then sweep the whole address space
    set_wr(1, 13, 32'h77, 4'hF); step();
    for (int a = 15; a >= 0; a--) begin
      set_rd(1, a); set_rd(0, a);
      step();
    end
    repeat (3) step();

    // Reset in the middle of the clear, and the clear must restart in full
    do_reset(2);
    repeat (8) begin
      for (int k = 0; k < 2; k++) rand_inputs(k);
      step();
    end
    do_reset(2);
    count_busy(1'b1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++) rand_inputs(k);
      step();
    end

    // Drain outstanding results with a bounded wait
    for (int n = 0; n < 10 && (exp_q0.size() > 0 || exp_q1.size() > 0); n++) step();
    repeat (2) step();
    compared++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d/%0d results still outstanding, want 0/0", exp_q0.size(), exp_q1.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
